cpu_dmem_responder: RTL and testbench

- Data-memory responder for the cpu_32bit load/store port. It is the memory-side end of the CPU's mem_addr/mem_we/mem_re interface.
- Owns a word-addressed RAM and accepts one request at a time.
- Inserts configurable wait states, then returns read data with a one-cycle ready pulse.
- Flags misaligned and out-of-range accesses with an error pulse instead of corrupting memory.

---
 rtl/cpu_dmem_responder.sv | 135 +++++++++++++
 tb/tb_cpu_dmem_responder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/cpu_dmem_responder.sv
// cpu_dmem_responder: memory-side end of the cpu_32bit load/store port.
// Owns a word-addressed RAM and serves one request at a time. Each request
// is registered, held for WAIT_STATES extra cycles, and then answered with
// a one-cycle mem_ready pulse. Misaligned, out-of-range and dual (we+re)
// requests are answered with mem_err and never touch the RAM.
// Optional build macro DMEM_PARITY_EN adds a per-word even-parity bit, a
// parity check on reads, and the parity_inject test port.
module cpu_dmem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic        mem_re,
`ifdef DMEM_PARITY_EN
  input  logic        parity_inject,
`endif
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        busy
);

  localparam int WORDS = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_nx;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic                  we_q;
  logic                  err_q;

  logic [31:0]           ram [WORDS];

  logic                  accept;
  logic                  commit;
  logic                  req_err;
  logic [31:0]           rd_word;
  logic                  rd_bad;

  // A new request is taken only from IDLE, so a request still held high in
  // the RESP cycle is ignored and at least one idle edge separates two
  // transactions.
  assign accept = (state == IDLE) && (mem_we || mem_re);

  // The RESP entry edge: write commit and read capture both happen here.
  // The request spends one registration cycle in WAIT plus WAIT_STATES
  // countdown cycles, which gives ready in the cycle after edge N+1+WS.
  assign commit = (state == WAIT) && (cnt == 4'd0);

  // Out-of-range addresses are rejected rather than aliased onto low words.
  assign req_err = (mem_addr[1:0] != 2'b00)
                 || ((mem_addr >> (DEPTH_LOG2 + 2)) != 32'd0)
                 || (mem_we && mem_re);

  assign rd_word = ram[idx_q];

`ifdef DMEM_PARITY_EN
  logic ram_par [WORDS];

  // Even parity over the stored word; a mismatch means the word is suspect.
  assign rd_bad = (^rd_word) != ram_par[idx_q];

  // Parity storage follows the data RAM; inject flips it for testing.
  always_ff @(posedge clk)
    if (commit && we_q && !err_q) ram_par[idx_q] <= (^wdata_q) ^ parity_inject;
`else
  assign rd_bad = 1'b0;
`endif

  // RAM write port; no reset so contents survive rst, and a dropped
  // transaction never reaches commit because state is forced to IDLE.
  always_ff @(posedge clk)
    if (commit && we_q && !err_q) ram[idx_q] <= wdata_q;

  // State register.
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  // Next-state and response strobes.
  always_comb begin
    state_nx  = state;
    mem_ready = 1'b0;
    mem_err   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = WAIT;
      WAIT: begin
        busy = 1'b1;
        if (cnt == 4'd0) state_nx = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        mem_ready = 1'b1;
        mem_err   = err_q;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request capture, wait countdown and response data register.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt       <= 4'd0;
      idx_q     <= '0;
      wdata_q   <= 32'd0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      mem_rdata <= 32'd0;
    end else begin
      if (accept) begin
        idx_q   <= mem_addr[DEPTH_LOG2+1:2];
        wdata_q <= mem_wdata;
        we_q    <= mem_we;
        err_q   <= req_err;
        cnt     <= 4'(WAIT_STATES);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        // Reads return data (even on parity error); writes and rejects give 0.
        if (!we_q && !err_q) mem_rdata <= rd_word;
        else                 mem_rdata <= 32'd0;
        if (!we_q && !err_q && rd_bad) err_q <= 1'b1;
      end
    end

endmodule

// File: tb/tb_cpu_dmem_responder.sv
// Directed bench for cpu_dmem_responder: three instances with
// WAIT_STATES = 1, 0 and 3 share clock, reset, address and data buses;
// each has its own request strobes and outputs.
module tb_cpu_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        pinj = 1'b0;
  logic        we_v [3];
  logic        re_v [3];
  logic [31:0] rdata [3];
  logic        rdy [3];
  logic        err [3];
  logic        bsy [3];

  int vectors = 0;
  int miscompares = 0;
  int ws_of [3] = '{1, 0, 3};

  always #5 clk = ~clk;

  cpu_dmem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(1)) dut_ws1 (
    .clk(clk), .rst(rst), .mem_addr(addr), .mem_wdata(wdata),
    .mem_we(we_v[0]), .mem_re(re_v[0]),
`ifdef DMEM_PARITY_EN
    .parity_inject(pinj),
`endif
    .mem_rdata(rdata[0]), .mem_ready(rdy[0]), .mem_err(err[0]), .busy(bsy[0]));

  cpu_dmem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst(rst), .mem_addr(addr), .mem_wdata(wdata),
    .mem_we(we_v[1]), .mem_re(re_v[1]),
`ifdef DMEM_PARITY_EN
    .parity_inject(pinj),
`endif
    .mem_rdata(rdata[1]), .mem_ready(rdy[1]), .mem_err(err[1]), .busy(bsy[1]));

  cpu_dmem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(3)) dut_ws3 (
    .clk(clk), .rst(rst), .mem_addr(addr), .mem_wdata(wdata),
    .mem_we(we_v[2]), .mem_re(re_v[2]),
`ifdef DMEM_PARITY_EN
    .parity_inject(pinj),
`endif
    .mem_rdata(rdata[2]), .mem_ready(rdy[2]), .mem_err(err[2]), .busy(bsy[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full transaction on instance k: drive at negedge, accept at the next
  // edge, expect ready after exactly WS+1 further edges, then release.
  task automatic do_req(input int k, input logic [31:0] a, input logic [31:0] d,
                        input logic we, input logic re, input logic exp_err,
                        input logic [31:0] exp_rd, input string tag);
    int n;
    @(negedge clk);
    addr = a; wdata = d; we_v[k] = we; re_v[k] = re;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!rdy[k] && n < 20);
    chk({tag, "_lat"}, 32'(n), 32'(ws_of[k] + 1));
    chk({tag, "_err"}, {31'd0, err[k]}, {31'd0, exp_err});
    chk({tag, "_rdata"}, rdata[k], exp_rd);
    @(negedge clk);
    we_v[k] = 1'b0; re_v[k] = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_rdyoff"}, {31'd0, rdy[k]}, 32'd0);
    chk({tag, "_idle"}, {31'd0, bsy[k]}, 32'd0);
  endtask

  initial begin
    int seen;
    for (int k = 0; k < 3; k++) begin we_v[k] = 1'b0; re_v[k] = 1'b0; end

    // Reset state of every instance.
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("rst_rdata", rdata[k], 32'd0);
      chk("rst_ready", {31'd0, rdy[k]}, 32'd0);
      chk("rst_err", {31'd0, err[k]}, 32'd0);
      chk("rst_busy", {31'd0, bsy[k]}, 32'd0);
    end
    @(negedge clk); rst = 1'b0;

    // WS=1: write then read back.
    do_req(0, 32'h0, 32'h0000001E, 1'b1, 1'b0, 1'b0, 32'h0, "ws1_wr");
    do_req(0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0000001E, "ws1_rd");

    // WS=0: write, then read held through RESP; it is accepted only after
    // one idle edge.
    @(negedge clk);
    addr = 32'h4; wdata = 32'hDEADBEEF; we_v[1] = 1'b1;
    @(posedge clk); #1;
    chk("ws0_wr_busy", {31'd0, bsy[1]}, 32'd1);
    chk("ws0_wr_notyet", {31'd0, rdy[1]}, 32'd0);
    @(posedge clk); #1;
    chk("ws0_wr_ready", {31'd0, rdy[1]}, 32'd1);
    chk("ws0_wr_err", {31'd0, err[1]}, 32'd0);
    @(negedge clk);
    we_v[1] = 1'b0; re_v[1] = 1'b1;
    @(posedge clk); #1;
    chk("ws0_gap_busy", {31'd0, bsy[1]}, 32'd0);
    chk("ws0_gap_ready", {31'd0, rdy[1]}, 32'd0);
    @(posedge clk); #1;
    chk("ws0_acc_busy", {31'd0, bsy[1]}, 32'd1);
    chk("ws0_acc_ready", {31'd0, rdy[1]}, 32'd0);
    @(posedge clk); #1;
    chk("ws0_rd_ready", {31'd0, rdy[1]}, 32'd1);
    chk("ws0_rd_rdata", rdata[1], 32'hDEADBEEF);
    @(negedge clk); re_v[1] = 1'b0;
    @(posedge clk); #1;
    chk("ws0_rd_hold", rdata[1], 32'hDEADBEEF);

    // Misaligned and out-of-range reads are rejected; memory untouched.
    do_req(1, 32'h6, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, "misalign");
    do_req(1, 32'h400, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, "range");
    do_req(1, 32'h4, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, "rd4_again");

    // Dual request is an errored, suppressed write.
    do_req(1, 32'h8, 32'h11111111, 1'b1, 1'b0, 1'b0, 32'h0, "wr8");
    do_req(1, 32'h8, 32'h22222222, 1'b1, 1'b1, 1'b1, 32'h0, "dual");
    do_req(1, 32'h8, 32'h0, 1'b0, 1'b1, 1'b0, 32'h11111111, "rd8");

`ifdef DMEM_PARITY_EN
    // Injected parity error is reported while data is still returned.
    pinj = 1'b1;
    do_req(0, 32'h10, 32'h00000001, 1'b1, 1'b0, 1'b0, 32'h0, "par_wr_bad");
    pinj = 1'b0;
    do_req(0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 32'h00000001, "par_rd_bad");
    do_req(0, 32'h10, 32'h00000001, 1'b1, 1'b0, 1'b0, 32'h0, "par_wr_ok");
    do_req(0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 32'h00000001, "par_rd_ok");
`endif

    // WS=3: reset two cycles after acceptance drops the write.
    do_req(2, 32'hC, 32'hAAAA5555, 1'b1, 1'b0, 1'b0, 32'h0, "ws3_wr_old");
    @(negedge clk);
    addr = 32'hC; wdata = 32'h12345678; we_v[2] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    chk("ws3_mid_busy", {31'd0, bsy[2]}, 32'd1);
    rst = 1'b1; #1;
    chk("ws3_rst_busy", {31'd0, bsy[2]}, 32'd0);
    chk("ws3_rst_ready", {31'd0, rdy[2]}, 32'd0);
    chk("ws1_rst_rdata", rdata[0], 32'd0);
    @(negedge clk); we_v[2] = 1'b0;
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rdy[2] || err[2] || bsy[2]) seen++;
    end
    chk("ws3_no_pulse", 32'(seen), 32'd0);
    do_req(2, 32'hC, 32'h0, 1'b0, 1'b1, 1'b0, 32'hAAAA5555, "ws3_rd_old");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
